// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM states, grant-side encoding,
// watchdog width and default timeout.
package mem_arb_pkg;

    localparam int unsigned TIMEOUT_CYCLES_DEF = 255;
    localparam int          WD_W               = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and shared-memory bus signals of the arbiter; master is the
// arbiter side, slave is the environment (requesters plus memory).
interface mem_port_arbiter_if;

    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;

    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ready;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ready,
        output i_rdata, i_ack, d_rdata, d_ack, m_req, m_we, m_addr, m_wdata
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ready,
        input  i_rdata, i_ack, d_rdata, d_ack, m_req, m_we, m_addr, m_wdata
    );

endinterface

// File: rtl/mem_port_arbiter_watchdog.sv
// Busy-cycle watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the count reaches the limit.
module mem_arb_watchdog
    import mem_arb_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            clear_i,
    input  logic            enable_i,
    input  logic [WD_W-1:0] limit_i,
    output logic            expired_o
);

    logic [WD_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q holds the number of busy cycles already elapsed, so this cycle is number cnt_q+1
    assign expired_o = enable_i && (({1'b0, cnt_q} + 9'd1) >= {1'b0, limit_i});

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch/data) arbiter onto one shared memory port with a
// busy watchdog. Define MEM_ARB_RR_EN for round-robin tie-breaking.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.master bus,
    output logic               err
);

    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

    state_e      state_q, state_d;
    gnt_e        gnt_q, gnt_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        err_q, err_d;
    logic        busy;
    logic        wd_expired;
    logic        pick_d;

    assign busy = (state_q == ST_BUSY_I) || (state_q == ST_BUSY_D);

    mem_arb_watchdog u_wd (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (!busy),
        .enable_i  (busy),
        .limit_i   (WD_LIMIT),
        .expired_o (wd_expired)
    );

`ifdef MEM_ARB_RR_EN
    gnt_e last_q, last_d;

    // On a tie the side that did not win the previous grant goes first
    assign pick_d = bus.d_req && (!bus.i_req || (last_q == GNT_I));

    always_comb begin
        last_d = last_q;
        if ((state_q == ST_IDLE) && (bus.d_req || bus.i_req)) begin
            last_d = pick_d ? GNT_D : GNT_I;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_q <= GNT_I;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign pick_d = bus.d_req;
`endif

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        err_d     = err_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_d) begin
                    state_d = ST_BUSY_D;
                    gnt_d   = GNT_D;
                    addr_d  = word_align(bus.d_addr);
                    we_d    = bus.d_we;
                    wdata_d = bus.d_wdata;
                end else if (bus.i_req) begin
                    state_d = ST_BUSY_I;
                    gnt_d   = GNT_I;
                    addr_d  = word_align(bus.i_addr);
                    we_d    = 1'b0;
                    wdata_d = '0;
                end
            end
            ST_BUSY_I, ST_BUSY_D: begin
                // Memory completion takes precedence over a watchdog expiry in the same cycle
                if (bus.m_ready) begin
                    state_d = ST_RESP;
                    if (gnt_q == GNT_D) begin
                        d_rdata_d = we_q ? 32'd0 : bus.m_rdata;
                    end else begin
                        i_rdata_d = bus.m_rdata;
                    end
                end else if (wd_expired) begin
                    state_d = ST_RESP;
                    err_d   = 1'b1;
                    if (gnt_q == GNT_D) begin
                        d_rdata_d = '0;
                    end else begin
                        i_rdata_d = '0;
                    end
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            gnt_q     <= GNT_I;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            err_q     <= err_d;
        end
    end

    assign bus.m_req   = busy;
    assign bus.m_we    = busy && we_q;
    assign bus.m_addr  = addr_q;
    assign bus.m_wdata = wdata_q;
    assign bus.i_ack   = (state_q == ST_RESP) && (gnt_q == GNT_I);
    assign bus.d_ack   = (state_q == ST_RESP) && (gnt_q == GNT_D);
    assign bus.i_rdata = i_rdata_q;
    assign bus.d_rdata = d_rdata_q;
    assign err         = err_q;

endmodule
